// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
// Holds the FSM state encoding, the slice width and the saturation helper
// used when the ADDSUB_SAT_EN build macro is defined.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturated two's-complement extreme for a w-bit word (w <= 32).
    // sign=0 gives the largest positive value, sign=1 the most negative.
    function automatic logic [31:0] sat_value(input logic sign, input int unsigned w);
        logic [31:0] msb;
        msb = 32'd1 << (w - 1);
        return sign ? msb : (msb - 32'd1);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_slice4.sv
// Combinational 4-bit add/subtract slice.
// When s=1 the b operand is inverted here, so the caller supplies the raw
// operand nibble and a carry-in that already folds in the +1 of negation.
module addsub_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       s,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);

    logic [3:0] w_b_eff;
    logic [4:0] w_total;

    assign w_b_eff = b ^ {4{s}};
    assign w_total = {1'b0, a} + {1'b0, w_b_eff} + {4'b0000, ci};
    assign sum     = w_total[3:0];
    assign co      = w_total[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial wide adder/subtractor sequencer.
// One operand pair per transaction is walked LSB-first through a single
// 4-bit slice, one nibble per clock, with the inter-nibble carry in a flop.
// Result, carry and signed overflow are presented on a valid/ready output.
// Build macro ADDSUB_SAT_EN: when defined, an overflowing result is replaced
// by the saturated extreme; cout and ovf still describe the raw operation.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    op_a,
    input  logic [4*NIBBLES-1:0]    op_b,
    input  logic                    sub,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    result,
    output logic                    cout,
    output logic                    ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic             r_sub;
    logic [W-1:0]     r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum_nib;
    logic             w_co;
    logic             w_ovf;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_nib  = r_op_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_b_nib  = r_op_b[NIBBLE_W*r_idx +: NIBBLE_W];

    // Overflow: operands (after the subtract inversion) agree in sign but the
    // raw MSB differs; only meaningful on the last nibble.
    assign w_ovf = (r_op_a[W-1] == (r_op_b[W-1] ^ r_sub)) &&
                   (w_sum_nib[3] != r_op_a[W-1]);

    addsub_slice4 u_slice (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .s   (r_sub),
        .ci  (r_carry),
        .sum (w_sum_nib),
        .co  (w_co)
    );

`ifdef ADDSUB_SAT_EN
    logic [W-1:0] w_sat_val;
    assign w_sat_val = W'(sat_value(r_op_a[W-1], W));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept, walk all nibbles, hold until consumed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = EXEC;
            EXEC:    if (w_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; not ready while reset is held.
    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
    end

    // Operand capture; contents only matter once a transaction is accepted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_a <= op_a;
            r_op_b <= op_b;
            r_sub  <= sub;
        end
    end

    // Nibble index and inter-nibble carry; for subtract the carry-in is
    // inverted so that A + ~B + ~cin equals A - B - cin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_idx   <= '0;
                r_carry <= cin ^ sub;
            end
        end else if (r_state == EXEC) begin
            r_carry <= w_co;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Result assembly nibble by nibble, flags captured on the last nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_result[NIBBLE_W*r_idx +: NIBBLE_W] <= w_sum_nib;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_ovf;
`ifdef ADDSUB_SAT_EN
                if (w_ovf) begin
                    r_result <= w_sat_val;
                end
`endif
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
